// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the shift-add multiplier: drives B-register and accumulator strobes.
// Optional macro MULT_DONE_HOLD_EN adds an ack input and holds done until acknowledged.
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// LOAD  | load B from db, clear accumulator, reset iteration count
// TEST  | wait one cycle for qb0 to settle, then choose add or skip
// ADD   | add multiplicand into accumulator
// SHIFT | shift A:carry and B right, count one iteration
// DONE  | product valid
module mult_seq_ctrl #(
   parameter  int WIDTH = 4,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic          qb0,
`ifdef MULT_DONE_HOLD_EN
   input  logic          ack,
`endif
   output logic          ldb,
   output logic          shb,
   output logic          clra,
   output logic          adda,
   output logic          sha,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] iter
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      TEST  = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [CW-1:0] ITER_MAX  = CW'(WIDTH);
   localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] iter_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Saturating iteration count; never wraps past WIDTH.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         iter_q <= '0;
      end else if (state == LOAD) begin
         iter_q <= '0;
      end else if ((state == SHIFT) && (iter_q != ITER_MAX)) begin
         iter_q <= iter_q + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      ldb       = 1'b0;
      clra      = 1'b0;
      adda      = 1'b0;
      shb       = 1'b0;
      sha       = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            ldb       = 1'b1;
            clra      = 1'b1;
            state_nxt = TEST;
         end
         TEST: begin
            state_nxt = qb0 ? ADD : SHIFT;
         end
         ADD: begin
            adda      = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            shb       = 1'b1;
            sha       = 1'b1;
            state_nxt = (iter_q == ITER_LAST) ? DONE : TEST;
         end
         DONE: begin
            done = 1'b1;
`ifdef MULT_DONE_HOLD_EN
            if (ack) state_nxt = IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign iter = iter_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl with a behavioural B shift register model.
// Exercises the MULT_DONE_HOLD_EN variant when that macro is defined.
module tb_mult_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int CW    = $clog2(WIDTH + 1);

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          start = 1'b0;
   logic          qb0;
`ifdef MULT_DONE_HOLD_EN
   logic          ack = 1'b0;
`endif
   logic          ldb, shb, clra, adda, sha, busy, done;
   logic [CW-1:0] iter;

   logic [WIDTH-1:0] db = '0;
   logic [WIDTH-1:0] breg = '0;

   int tests = 0;
   int fails = 0;

   mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .clr  (clr),
      .start(start),
      .qb0  (qb0),
`ifdef MULT_DONE_HOLD_EN
      .ack  (ack),
`endif
      .ldb  (ldb),
      .shb  (shb),
      .clra (clra),
      .adda (adda),
      .sha  (sha),
      .busy (busy),
      .done (done),
      .iter (iter)
   );

   always #5 clk = ~clk;

   // B register model driven by the controller strobes.
   always @(posedge clk) begin
      if (ldb)      breg <= db;
      else if (shb) breg <= breg >> 1;
   end
   assign qb0 = breg[0];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Starts a multiply with operand b and follows it to done, recording the strobe trace.
   task automatic run_seq(input logic [WIDTH-1:0] b, input bit hold_start, input bit repulse,
                          output int lat, output string seq, output int na, output int ns,
                          output bit excl_ok, output logic [CW-1:0] iter_done);
      bit got_done;
      db        = b;
      start     = 1'b1;
      lat       = 0;
      seq       = "";
      na        = 0;
      ns        = 0;
      excl_ok   = 1'b1;
      iter_done = '0;
      got_done  = 1'b0;
      tick();
      if (!hold_start) start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         lat = n;
         if ((ldb + adda + shb) > 1 || sha !== shb || clra !== ldb) excl_ok = 1'b0;
         if (done)       seq = {seq, "D"};
         else if (ldb)   seq = {seq, "L"};
         else if (adda)  seq = {seq, "A"};
         else if (shb)   seq = {seq, "S"};
         else if (busy)  seq = {seq, "T"};
         else            seq = {seq, "I"};
         if (adda) na++;
         if (shb)  ns++;
         if (done) begin
            iter_done = iter;
            got_done  = 1'b1;
            break;
         end
         if (repulse && shb && iter == CW'(1)) start = 1'b1;
         tick();
         if (repulse && !hold_start) start = 1'b0;
      end
      if (!got_done) begin
         tests++;
         fails++;
         $display("FAIL run_timeout: done not seen in 40 cycles, b=%b", b);
      end
   endtask

   task automatic finish_done();
`ifdef MULT_DONE_HOLD_EN
      ack = 1'b1;
`endif
      tick();
`ifdef MULT_DONE_HOLD_EN
      ack = 1'b0;
`endif
   endtask

   task automatic check_run(input string name, input logic [WIDTH-1:0] b, input bit repulse,
                            input string exp_seq, input int exp_lat, input int exp_na);
      int lat, na, ns;
      string seq;
      bit excl;
      logic [CW-1:0] it;
      run_seq(b, 1'b0, repulse, lat, seq, na, ns, excl, it);
      tests++;
      if (seq != exp_seq) begin
         fails++;
         $display("FAIL %s_seq: got %s expected %s", name, seq, exp_seq);
      end
      tests++;
      if (lat != exp_lat) begin
         fails++;
         $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
      tests++;
      if (na != exp_na || ns != WIDTH) begin
         fails++;
         $display("FAIL %s_counts: adda %0d shb %0d expected adda %0d shb %0d", name, na, ns, exp_na, WIDTH);
      end
      tests++;
      if (it !== CW'(WIDTH)) begin
         fails++;
         $display("FAIL %s_iter: got %0d expected %0d", name, it, WIDTH);
      end
      check_bit({name, "_exclusion"}, excl, 1'b1);
      finish_done();
      check_bit({name, "_idle_busy"}, busy, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         if (done) finish_done();
         else      tick();
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s_idle_timeout: busy still %b", name, busy);
      end
   endtask

   task automatic test_reset();
      clr   = 1'b1;
      start = 1'b1;
      #20;
      tests++;
      if ({ldb, shb, clra, adda, sha, busy, done} !== 7'b0 || iter !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got strobes %b iter %0d expected 0000000 iter 0",
                  {ldb, shb, clra, adda, sha, busy, done}, iter);
      end
      @(posedge clk);
      #1;
      check_bit("reset_held_idle", busy, 1'b0);
      clr = 1'b0;
      tick();
      check_bit("reset_release_load", ldb, 1'b1);
      start = 1'b0;
      wait_idle("reset");
   endtask

   task automatic test_patterns();
      check_run("b1001", 4'b1001, 1'b0, "LTASTSTSTASD", 12, 2);
      check_run("b0000", 4'b0000, 1'b0, "LTSTSTSTSD", 10, 0);
      check_run("b1111", 4'b1111, 1'b0, "LTASTASTASTASD", 14, 4);
   endtask

   task automatic test_start_while_busy();
      check_run("repulse", 4'b1001, 1'b1, "LTASTSTSTASD", 12, 2);
   endtask

   task automatic test_back_to_back();
      int lat, na, ns;
      string seq;
      bit excl;
      logic [CW-1:0] it;
      run_seq(4'b0110, 1'b1, 1'b0, lat, seq, na, ns, excl, it);
      tests++;
      if (seq != "LTSTASTASTSD" || lat != 12) begin
         fails++;
         $display("FAIL held_start_seq: got %s lat %0d expected LTSTASTASTSD lat 12", seq, lat);
      end
      finish_done();
      check_bit("held_start_idle", busy, 1'b0);
      tick();
      check_bit("held_start_reload", ldb, 1'b1);
      start = 1'b0;
      wait_idle("held_start");
   endtask

   task automatic test_reset_mid_add();
      bit seen = 1'b0;
      db    = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (adda) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check_bit("mid_add_reached", seen, 1'b1);
      clr = 1'b1;
      #1;
      tests++;
      if ({ldb, shb, clra, adda, sha, busy, done} !== 7'b0 || iter !== '0) begin
         fails++;
         $display("FAIL mid_add_reset: got strobes %b iter %0d expected 0000000 iter 0",
                  {ldb, shb, clra, adda, sha, busy, done}, iter);
      end
      @(posedge clk);
      #1;
      clr = 1'b0;
      tick();
      check_run("after_reset", 4'b1001, 1'b0, "LTASTSTSTASD", 12, 2);
   endtask

`ifdef MULT_DONE_HOLD_EN
   task automatic test_done_hold();
      int lat, na, ns;
      string seq;
      bit excl;
      logic [CW-1:0] it;
      bit held = 1'b1;
      run_seq(4'b0001, 1'b0, 1'b0, lat, seq, na, ns, excl, it);
      check_bit("hold_first_done", done, 1'b1);
      start = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (done !== 1'b1 || ldb !== 1'b0) held = 1'b0;
      end
      check_bit("hold_done_held", held, 1'b1);
      start = 1'b0;
      ack   = 1'b1;
      tick();
      ack   = 1'b0;
      check_bit("hold_ack_idle", busy, 1'b0);
      check_bit("hold_ack_done_low", done, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_patterns();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_add();
`ifdef MULT_DONE_HOLD_EN
      test_done_hold();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
